// File: rtl/cpu_trace_buffer.sv
// Execution-trace capture unit: records PC and register-write events during a run
// into a circular or stop-on-full buffer that is drained through a show-ahead pop port.
module cpu_trace_buffer #(
  parameter int PC_W       = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 64,
  parameter int MAX_CYCLES = 30,
  parameter int CNT_W      = 16,
  parameter int MODE       = 0,
  parameter int WRAP       = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  start_i,
  input  logic                                  clear_i,
  input  logic [PC_W-1:0]                       pc_i,
  input  logic                                  reg_wr_i,
  input  logic [4:0]                            reg_addr_i,
  input  logic [DATA_W-1:0]                     reg_data_i,
  input  logic                                  rd_en_i,
  output logic                                  rd_valid_o,
  output logic [CNT_W+PC_W+1+5+DATA_W-1:0]      rd_data_o,
  output logic [$clog2(DEPTH):0]                count_o,
  output logic [CNT_W-1:0]                      cycle_o,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic                                  overflow_o
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = CNT_W + PC_W + 1 + 5 + DATA_W;
  localparam logic [CNT_W-1:0] LAST_STAMP = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic               overflow_q, overflow_d;
  logic               mem_we;
  logic [ENTRY_W-1:0] entry;
  logic               capture;
  logic               push;
  logic               pop;
  logic               full;

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    cycle_d    = cycle_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    entry      = {cycle_q, pc_i, reg_wr_i, reg_addr_i, reg_data_i};
    capture    = start_i && (state_q != DONE);
    push       = capture && ((MODE == 0) ? 1'b1 : reg_wr_i);
    full       = (count_q == (AW+1)'(DEPTH));
    pop        = rd_en_i && (count_q != '0);

    if (clear_i) begin
      state_d    = IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      cycle_d    = '0;
      overflow_d = 1'b0;
    end else begin
      // Entering RUN from IDLE is itself a capture cycle, so both states share this path.
      if (capture) begin
        cycle_d = sat_inc(cycle_q);
        if ((MAX_CYCLES != 0) && (cycle_q == LAST_STAMP)) state_d = DONE;
        else                                              state_d = RUN;
      end

      if (push && pop) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else if (push && full) begin
        overflow_d = 1'b1;
        if (WRAP != 0) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          rd_ptr_d = rd_ptr_q + AW'(1);
        end
      end else if (push) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = count_q + (AW+1)'(1);
      end else if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        count_d  = count_q - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cycle_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cycle_q    <= cycle_d;
      overflow_q <= overflow_d;
    end
  end

  // Trace storage holds no control state, so it is left out of reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[wr_ptr_q] <= entry;
  end

  assign rd_valid_o = (count_q != '0);
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign cycle_o    = cycle_q;
  assign busy_o     = (state_q == RUN);
  assign done_o     = (state_q == DONE);
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer: four instances with different depth, filter
// and full behaviour share one stimulus bus; a forked monitor checks every popped entry.
module tb_cpu_trace_buffer;

  localparam int PW = 32;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int EW = CW + PW + 1 + 5 + DW;

  logic          clk;
  logic          rst;
  logic          start [4];
  logic          clear [4];
  logic          rd_en [4];
  logic [PW-1:0] pc;
  logic          reg_wr;
  logic [4:0]    reg_addr;
  logic [DW-1:0] reg_data;

  logic          rdv  [4];
  logic [EW-1:0] rdd  [4];
  logic [CW-1:0] cyc  [4];
  logic          busy [4];
  logic          done [4];
  logic          ovf  [4];
  logic [6:0]    cnt0, cnt1;
  logic [2:0]    cnt2, cnt3;

  logic [EW-1:0] q0[$];
  logic [EW-1:0] q1[$];
  logic [EW-1:0] q2[$];
  logic [EW-1:0] q3[$];

  int total;
  int bad;

  cpu_trace_buffer #(.DEPTH(64), .MAX_CYCLES(30), .MODE(0), .WRAP(1)) u0 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .clear_i(clear[0]), .pc_i(pc),
    .reg_wr_i(reg_wr), .reg_addr_i(reg_addr), .reg_data_i(reg_data), .rd_en_i(rd_en[0]),
    .rd_valid_o(rdv[0]), .rd_data_o(rdd[0]), .count_o(cnt0), .cycle_o(cyc[0]),
    .busy_o(busy[0]), .done_o(done[0]), .overflow_o(ovf[0]));

  cpu_trace_buffer #(.DEPTH(64), .MAX_CYCLES(30), .MODE(1), .WRAP(1)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .clear_i(clear[1]), .pc_i(pc),
    .reg_wr_i(reg_wr), .reg_addr_i(reg_addr), .reg_data_i(reg_data), .rd_en_i(rd_en[1]),
    .rd_valid_o(rdv[1]), .rd_data_o(rdd[1]), .count_o(cnt1), .cycle_o(cyc[1]),
    .busy_o(busy[1]), .done_o(done[1]), .overflow_o(ovf[1]));

  cpu_trace_buffer #(.DEPTH(4), .MAX_CYCLES(10), .MODE(0), .WRAP(1)) u2 (
    .clk_i(clk), .rst_i(rst), .start_i(start[2]), .clear_i(clear[2]), .pc_i(pc),
    .reg_wr_i(reg_wr), .reg_addr_i(reg_addr), .reg_data_i(reg_data), .rd_en_i(rd_en[2]),
    .rd_valid_o(rdv[2]), .rd_data_o(rdd[2]), .count_o(cnt2), .cycle_o(cyc[2]),
    .busy_o(busy[2]), .done_o(done[2]), .overflow_o(ovf[2]));

  cpu_trace_buffer #(.DEPTH(4), .MAX_CYCLES(10), .MODE(0), .WRAP(0)) u3 (
    .clk_i(clk), .rst_i(rst), .start_i(start[3]), .clear_i(clear[3]), .pc_i(pc),
    .reg_wr_i(reg_wr), .reg_addr_i(reg_addr), .reg_data_i(reg_data), .rd_en_i(rd_en[3]),
    .rd_valid_o(rdv[3]), .rd_data_o(rdd[3]), .count_o(cnt3), .cycle_o(cyc[3]),
    .busy_o(busy[3]), .done_o(done[3]), .overflow_o(ovf[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] ent(input int c, input int p, input bit wr,
                                         input int a, input int d);
    return {CW'(c), PW'(p), wr, 5'(a), DW'(d)};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int k, input logic [EW-1:0] e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic mon(input int k);
    logic [EW-1:0] e;
    bit have;
    have = 1'b0;
    e = '0;
    case (k)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
    endcase
    total++;
    if (!have) begin
      bad++;
      $display("FAIL pop_unexpected%0d: got %h expected nothing", k, rdd[k]);
    end else if (rdd[k] !== e) begin
      bad++;
      $display("FAIL pop_data%0d: got %h expected %h", k, rdd[k], e);
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++)
        if (rd_en[k] && rdv[k]) mon(k);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int k, input int budget);
    int n;
    n = 0;
    rd_en[k] = 1'b1;
    while (rdv[k] && n < budget) begin
      step();
      n++;
    end
    step();
    rd_en[k] = 1'b0;
    chk($sformatf("drain_empty%0d", k), longint'(rdv[k]), 0);
    chk($sformatf("drain_left%0d", k), qsize(k), 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0;
    pc = '0; reg_wr = 1'b0; reg_addr = '0; reg_data = '0;
    for (int k = 0; k < 4; k++) begin
      start[k] = 1'b0; clear[k] = 1'b0; rd_en[k] = 1'b0;
    end
    fork
      monitor_loop();
    join_none
    step();
    step();
    rst = 1'b1;
    chk("rst_valid0", longint'(rdv[0]), 0);
    chk("rst_count0", cnt0, 0);
    chk("rst_cycle0", cyc[0], 0);
    chk("rst_busy0", longint'(busy[0]), 0);
    chk("rst_done0", longint'(done[0]), 0);
    chk("rst_ovf2", longint'(ovf[2]), 0);

    // Full run, every cycle captured.
    for (int i = 0; i < 32; i++) begin
      start[0] = 1'b1;
      pc = PW'(4 * i);
      if (i < 30) push_exp(0, ent(i, 4 * i, 1'b0, 0, 0));
      step();
      if (i == 28) chk("done_early0", longint'(done[0]), 0);
      if (i == 29) chk("done_rise0", longint'(done[0]), 1);
    end
    start[0] = 1'b0;
    chk("run_count0", cnt0, 30);
    chk("run_cycle0", cyc[0], 30);
    chk("run_busy0", longint'(busy[0]), 0);
    chk("run_ovf0", longint'(ovf[0]), 0);
    drain(0, 40);

    // Register-write filter.
    for (int i = 0; i < 12; i++) begin
      start[1] = 1'b1;
      pc = PW'(4 * i);
      reg_wr = 1'b0; reg_addr = 5'h1f; reg_data = 32'hdead;
      if (i == 3) begin reg_wr = 1'b1; reg_addr = 5'd8;  reg_data = 32'd5;  end
      if (i == 7) begin reg_wr = 1'b1; reg_addr = 5'd9;  reg_data = 32'd10; end
      if (i == 8) begin reg_wr = 1'b1; reg_addr = 5'd16; reg_data = 32'd15; end
      if (reg_wr) push_exp(1, ent(i, 4 * i, 1'b1, int'(reg_addr), int'(reg_data)));
      step();
    end
    start[1] = 1'b0; reg_wr = 1'b0; reg_addr = '0; reg_data = '0;
    chk("flt_count1", cnt1, 3);
    chk("flt_cycle1", cyc[1], 12);
    chk("flt_busy1", longint'(busy[1]), 1);
    drain(1, 10);

    // Small buffer, overwrite vs drop.
    for (int i = 0; i < 10; i++) begin
      start[2] = 1'b1; start[3] = 1'b1;
      pc = PW'(4 * i);
      if (i >= 6) push_exp(2, ent(i, 4 * i, 1'b0, 0, 0));
      if (i < 4)  push_exp(3, ent(i, 4 * i, 1'b0, 0, 0));
      step();
    end
    start[2] = 1'b0; start[3] = 1'b0;
    chk("wrap_count2", cnt2, 4);
    chk("wrap_ovf2", longint'(ovf[2]), 1);
    chk("wrap_done2", longint'(done[2]), 1);
    chk("wrap_cycle2", cyc[2], 10);
    chk("drop_count3", cnt3, 4);
    chk("drop_ovf3", longint'(ovf[3]), 1);
    chk("drop_done3", longint'(done[3]), 1);
    drain(2, 8);
    drain(3, 8);

    // Full buffer with a pop every cycle.
    clear[2] = 1'b1;
    step();
    clear[2] = 1'b0;
    chk("clr_count2", cnt2, 0);
    chk("clr_ovf2", longint'(ovf[2]), 0);
    chk("clr_done2", longint'(done[2]), 0);
    for (int i = 0; i < 10; i++) begin
      start[2] = 1'b1;
      rd_en[2] = (i >= 4);
      pc = PW'(4 * i);
      push_exp(2, ent(i, 4 * i, 1'b0, 0, 0));
      step();
      if (i >= 4) chk($sformatf("pp_count2_%0d", i), cnt2, 4);
    end
    start[2] = 1'b0; rd_en[2] = 1'b0;
    chk("pp_ovf2", longint'(ovf[2]), 0);
    chk("pp_done2", longint'(done[2]), 1);
    drain(2, 8);

    // Clear while DONE with start still held.
    start[2] = 1'b1; clear[2] = 1'b1;
    step();
    clear[2] = 1'b0;
    chk("cd_count2", cnt2, 0);
    chk("cd_cycle2", cyc[2], 0);
    chk("cd_valid2", longint'(rdv[2]), 0);
    chk("cd_done2", longint'(done[2]), 0);
    chk("cd_busy2", longint'(busy[2]), 0);
    pc = 32'h300;
    push_exp(2, ent(0, 32'h300, 1'b0, 0, 0));
    step();
    start[2] = 1'b0;
    chk("cd_cycle2b", cyc[2], 1);
    chk("cd_busy2b", longint'(busy[2]), 1);
    drain(2, 8);

    // Reset in the middle of a run.
    clear[0] = 1'b1;
    step();
    clear[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      start[0] = 1'b1;
      pc = PW'(32'h100 + 4 * i);
      push_exp(0, ent(i, 32'h100 + 4 * i, 1'b0, 0, 0));
      step();
    end
    chk("pre_rst_count0", cnt0, 12);
    rst = 1'b0;
    step();
    rst = 1'b1;
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    chk("mid_rst_count0", cnt0, 0);
    chk("mid_rst_cycle0", cyc[0], 0);
    chk("mid_rst_valid0", longint'(rdv[0]), 0);
    chk("mid_rst_busy0", longint'(busy[0]), 0);
    chk("mid_rst_done3", longint'(done[3]), 0);
    for (int i = 0; i < 3; i++) begin
      pc = PW'(32'h200 + 4 * i);
      push_exp(0, ent(i, 32'h200 + 4 * i, 1'b0, 0, 0));
      step();
    end
    start[0] = 1'b0;
    chk("restart_cycle0", cyc[0], 3);
    chk("restart_count0", cnt0, 3);
    drain(0, 8);

    // Pop requests on an empty buffer are ignored.
    rd_en[3] = 1'b1;
    step();
    step();
    rd_en[3] = 1'b0;
    chk("empty_pop_count3", cnt3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
- Synthesizable, parametrised execution-trace capture unit that sits beside the single-cycle/pipelined CPU.
- Replaces fixed per-cycle bench printing with on-chip recording of PC and register-write events.
- Adds a cycle limit, an event filter mode, and a circular or stop-on-full buffer.
- A simple pop interface lets a bench or debug port drain entries in order.

Parameters:
- PC_W, 32, PC width.
- DATA_W, 32, register write-data width.
- DEPTH, 64, trace entries; power of two, minimum 2.
- MAX_CYCLES, 30, run length in captured cycles; 0 means unlimited.
- CNT_W, 16, cycle-counter width; the counter saturates at all-ones.
- MODE, 0, capture filter: 0 = every run cycle, 1 = only cycles with reg_wr_i=1.
- WRAP, 1, full behaviour: 1 = overwrite oldest entry, 0 = drop new entries.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-low reset.
- start_i  in  1  level; capture enabled while high.
- clear_i  in  1  pulse; empties buffer, zeroes counters and flags, returns to IDLE.
- pc_i  in  PC_W  current PC.
- reg_wr_i  in  1  register file write this cycle.
- reg_addr_i  in  5  write register index.
- reg_data_i  in  DATA_W  write data.
- rd_en_i  in  1  pop request.
- rd_valid_o  out  1  buffer non-empty.
- rd_data_o  out  CNT_W+PC_W+1+5+DATA_W  head entry, packed MSB to LSB as {cycle, pc, wr, addr, data}.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- cycle_o  out  CNT_W  run cycles elapsed.
- busy_o  out  1  state is RUN.
- done_o  out  1  state is DONE.
- overflow_o  out  1  sticky; set when an entry was overwritten or dropped.

Behaviour:
- Reset (rst_i=0 at a posedge):
  - state=IDLE; read/write pointers, count_o and cycle_o = 0.
  - overflow_o, busy_o, done_o = 0; rd_valid_o = 0.
  - rd_data_o is don't-care while rd_valid_o=0.
  - Reset overrides every other input.
- States:
  - IDLE -> RUN when start_i=1. The transition cycle is itself a capture cycle with cycle stamp 0.
  - RUN: each posedge with start_i=1 is a run cycle.
    - The entry stamped with the current cycle_o is pushed if the MODE filter passes.
    - cycle_o then increments.
    - start_i=0 in RUN pauses: no push, no increment, state held.
  - RUN -> DONE at the posedge where the run cycle with stamp MAX_CYCLES-1 is processed. That cycle's entry is still captured.
  - DONE: no capture; popping is still allowed. Leave DONE only via clear_i or reset.
  - clear_i (any state) has priority over start_i and pushes in the same cycle; it also discards a simultaneous pop.
- Push and pop:
  - The entry captures the input values sampled at that posedge.
  - Pop when rd_en_i && rd_valid_o. rd_data_o is the show-ahead head, read combinationally from memory. The next entry is visible the cycle after a pop.
  - rd_en_i while empty is ignored without error.
  - Push and pop together, not full: both occur; count unchanged.
  - Push and pop together, full: both occur; no overflow.
  - Push while full without pop, WRAP=1: oldest overwritten, read pointer advances, count stays DEPTH, overflow_o=1.
  - Push while full without pop, WRAP=0: entry dropped, overflow_o=1.
- Pointers wrap modulo DEPTH. count_o ranges 0..DEPTH.
- cycle_o saturates at 2^CNT_W-1. The stamp stored in the entry is the pre-increment value.

Test Plan:
- MODE=0, DEPTH=64, MAX_CYCLES=30; start_i=1 held, pc_i = 4*cycle -> done_o rises after 30 capture cycles, count_o=30, cycle_o=30. Drain shows stamps 0..29 with pc 0,4,...,116; overflow_o=0.
- MODE=1; reg_wr_i high on cycles 3, 7, 8 with addr 8/9/16 and data 5/10/15 -> count_o=3. Entries are {3,pc3,1,8,5}, {7,pc7,1,9,10}, {8,pc8,1,16,15}.
- DEPTH=4, WRAP=1, MAX_CYCLES=10, MODE=0 -> count_o=4, overflow_o=1, drained stamps 6,7,8,9.
- DEPTH=4, WRAP=0, MAX_CYCLES=10 -> drained stamps 0,1,2,3; overflow_o=1.
- DEPTH=4; fill to 4, then hold rd_en_i=1 during RUN -> count_o stays 4, overflow_o=0. Popped stamps are consecutive with no gaps.
- rst_i=0 for one cycle at cycle 12 of a run -> next cycle state=IDLE, count_o=0, cycle_o=0, rd_valid_o=0. With start_i still 1, capture restarts at stamp 0. A clear_i pulse in DONE produces the identical result.
